// File: rtl/camera64x64_reader.sv
// camera64x64_reader: host-side serial reader for the 64x64 camera.
// Bursts SCLK per pixel and streams raster-ordered pixels with X/Y.
module camera64x64_reader #(
  parameter int SCLK_HALF  = 3,
  parameter int PIX_BITS   = 8,
  parameter int GAP_CYCLES = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic                SDATA,
  output logic                SCLK,
  output logic [PIX_BITS-1:0] PIX_DATA,
  output logic [5:0]          PIX_X,
  output logic [5:0]          PIX_Y,
  output logic                PIX_VALID,
  input  logic                PIX_READY,
  output logic                BUSY,
  output logic                FRAME_DONE
);

  localparam int DMAX =
    (SCLK_HALF > GAP_CYCLES) ? SCLK_HALF : GAP_CYCLES;
  localparam int DW = $clog2(DMAX + 1);
  localparam int BW = $clog2(PIX_BITS + 1);
  localparam logic [DW-1:0] HALF_END = DW'(SCLK_HALF - 1);
  localparam logic [DW-1:0] GAP_END  = DW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(PIX_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOW,
    S_HIGH,
    S_HOLD,
    S_GAP,
    S_DONE
  } state_t;

  state_t              r_state, w_state;
  logic [DW-1:0]       r_div, w_div;
  logic [BW-1:0]       r_bit, w_bit;
  logic [11:0]         r_cnt, w_cnt;
  logic [PIX_BITS-1:0] r_shift, w_shift;
  logic [PIX_BITS-1:0] r_data, w_data;
  logic                r_sclk, w_sclk;
  logic                r_valid, w_valid;
  logic                r_busy, w_busy;
  logic                r_done, w_done;
  logic                w_div_end;

  assign w_div_end = (r_state == S_GAP) ? (r_div == GAP_END)
                                        : (r_div == HALF_END);

  always_comb begin
    w_state = r_state;
    w_div   = r_div;
    w_bit   = r_bit;
    w_cnt   = r_cnt;
    w_shift = r_shift;
    w_data  = r_data;
    w_sclk  = r_sclk;
    w_valid = r_valid;
    w_busy  = r_busy;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (START) begin
          w_state = S_LOW;
          w_cnt   = '0;
          w_bit   = '0;
          w_div   = '0;
          w_busy  = 1'b1;
        end
      end
      S_LOW: begin
        if (w_div_end) begin
          // Bit is sampled on the edge that raises SCLK.
          w_div   = '0;
          w_sclk  = 1'b1;
          w_shift = {r_shift[PIX_BITS-2:0], SDATA};
          w_state = S_HIGH;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_HIGH: begin
        if (w_div_end) begin
          w_div  = '0;
          w_sclk = 1'b0;
          if (r_bit == BIT_END) begin
            w_data  = r_shift;
            w_valid = 1'b1;
            w_state = S_HOLD;
          end else begin
            w_bit   = r_bit + 1'b1;
            w_state = S_LOW;
          end
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_HOLD: begin
        if (PIX_READY) begin
          w_valid = 1'b0;
          if (r_cnt == 12'hFFF) begin
            w_state = S_DONE;
            w_done  = 1'b1;
            w_busy  = 1'b0;
          end else begin
            w_cnt   = r_cnt + 12'd1;
            w_state = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (w_div_end) begin
          w_div   = '0;
          w_bit   = '0;
          w_state = S_LOW;
        end else begin
          w_div = r_div + 1'b1;
        end
      end
      S_DONE: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_sclk  <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_div   <= w_div;
      r_bit   <= w_bit;
      r_cnt   <= w_cnt;
      r_shift <= w_shift;
      r_data  <= w_data;
      r_sclk  <= w_sclk;
      r_valid <= w_valid;
      r_busy  <= w_busy;
      r_done  <= w_done;
    end
  end

  assign SCLK       = r_sclk;
  assign PIX_DATA   = r_data;
  assign PIX_X      = r_cnt[5:0];
  assign PIX_Y      = r_cnt[11:6];
  assign PIX_VALID  = r_valid;
  assign BUSY       = r_busy;
  assign FRAME_DONE = r_done;

endmodule
